byte_serial_adder: RTL and testbench
====================================

// Module: byte_serial_adder
// PURPOSE
//   Multi-byte sequential adder built around one prefixadder8 slice. Captures
//   two NBYTES-byte operands on start, then adds one byte per cycle,
//   least-significant byte first, through the shared 8-bit prefix adder.
//   The inter-byte carry is held in a register. This is the operand
//   sequencer and carry stage directly upstream of prefixadder8; it drives
//   that slice's a/b/cin and consumes its s.
// PARAMETERS
//   NBYTES   4   operand width in bytes (>=1); total width W = 8*NBYTES
// PORTS
//   clk     in   1    clock, rising edge
//   reset   in   1    asynchronous, active-low reset (0 = reset)
//   start   in   1    request; sampled only in IDLE
//   a       in   W    operand A; captured on accepted start
//   b       in   W    operand B; captured on accepted start
//   cin     in   1    carry-in to byte 0; captured on accepted start
//   busy    out  1    high in RUN and DONE
//   done    out  1    one-cycle pulse; sum/cout valid
//   sum     out  W    result register
//   cout    out  1    carry out of the most-significant byte
// BEHAVIOUR
//   Reset (reset=0, async, at any time including mid-operation):
//     - state=IDLE; idx, a_q, b_q, carry_q, sum, cout, busy, done all 0.
//   Slice hookup: prefixadder8(a_q[idx], b_q[idx], carry_q, s_byte).
//     - The slice has no carry-out, so derive it:
//       c8 = a7&b7 | (a7^b7)&~s7, where a7/b7 are bit 7 of the current
//       operand bytes and s7 is bit 7 of s_byte.
//   FSM states: IDLE, RUN, DONE.
//   IDLE:
//     - start=1: capture a, b, cin (cin into carry_q); idx<=0; sum<=0;
//       cout<=0; go to RUN.
//     - start=0: hold all state. sum/cout keep the last result.
//   RUN, on each rising edge:
//     - sum byte idx <= s_byte; carry_q <= c8.
//     - idx < NBYTES-1: idx <= idx+1, stay in RUN.
//     - idx == NBYTES-1: cout <= c8, go to DONE.
//   DONE:
//     - done=1 for exactly this cycle; next state is IDLE unconditionally.
//   Latency: start sampled at edge 0; bytes are written at edges 1..NBYTES;
//     done is high in the cycle after edge NBYTES. Throughput is one
//     operation per NBYTES+2 cycles.
//   start during RUN or DONE: ignored; it is neither queued nor does it
//     corrupt captured operands.
//   Input changes after capture have no effect on the operation in progress.
//   Arithmetic: {cout,sum} = a + b + cin, modulo 2^(W+1). No overflow flag.
//   NBYTES=1: RUN lasts one cycle; idx is held at 0.
//   busy = (state != IDLE), registered-state decode. done = (state == DONE).
// TESTING (NBYTES=4)
//   1. Reset:
//      reset=0 -> busy=0, done=0, sum=0, cout=0; start held high during
//      reset has no effect.
//   2. Basic add:
//      a=0x00000017, b=0x00000013, cin=0, start pulse -> done exactly 4
//      cycles after the start edge; sum=0x0000002A, cout=0.
//   3. Inter-byte carry:
//      a=0x00FFFFFF, b=0x00000001, cin=0 -> sum=0x01000000, cout=0.
//   4. Full wrap:
//      a=0xFFFFFFFF, b=0x00000000, cin=1 -> sum=0x00000000, cout=1.
//   5. Start while busy:
//      start a=5, b=7; during RUN, pulse start with a=0xFF, b=0xFF ->
//      single done, sum=0x0000000C; busy drops the cycle after done.
//   6. Reset mid-RUN:
//      assert reset 2 cycles into RUN -> immediate IDLE, outputs 0, no done;
//      release, then start a=1, b=2 -> sum=3 after normal latency.

Source files
------------

// File: rtl/byte_serial_adder.sv
// byte_serial_adder: multi-byte add, one byte per cycle, through a shared 8-bit prefix adder
module prefixadder8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] s
);
  logic [7:0] g0, p0, g1, p1, g2, p2, g3, p3;
  logic [8:0] c;
  function automatic logic [15:0] lvl(input logic [7:0] g, input logic [7:0] p, input int d);
    logic [7:0] go, po;
    go = g;
    po = p;
    for (int i = 0; i < 8; i++)
      if (i >= d) begin
        go[i] = g[i] | (p[i] & g[i-d]);
        po[i] = p[i] & p[i-d];
      end
    return {go, po};
  endfunction
  assign g0 = a & b;
  assign p0 = a ^ b;
  assign {g1, p1} = lvl(g0, p0, 1);
  assign {g2, p2} = lvl(g1, p1, 2);
  assign {g3, p3} = lvl(g2, p2, 4);
  assign c = {g3 | (p3 & {8{cin}}), cin};
  assign s = p0 ^ c[7:0];
endmodule

module byte_serial_adder #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [8*NBYTES-1:0] a,
  input  logic [8*NBYTES-1:0] b,
  input  logic                cin,
  output logic                busy,
  output logic                done,
  output logic [8*NBYTES-1:0] sum,
  output logic                cout
);
  localparam int W = 8 * NBYTES;
  localparam int IW = NBYTES > 1 ? $clog2(NBYTES) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [IW-1:0] idx;
  logic [W-1:0] a_q, b_q;
  logic carry_q, c8, last;
  logic [7:0] a_byte, b_byte, s_byte;
  assign a_byte = a_q[idx*8 +: 8];
  assign b_byte = b_q[idx*8 +: 8];
  assign last = idx == IW'(NBYTES - 1);
  prefixadder8 u_slice (.a(a_byte), .b(b_byte), .cin(carry_q), .s(s_byte));
  // the slice has no carry-out; recover it from the top bit
  assign c8 = (a_byte[7] & b_byte[7]) | ((a_byte[7] ^ b_byte[7]) & ~s_byte[7]);
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = start ? RUN : IDLE;
      RUN:  state_n = last ? DONE : RUN;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      idx     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
    end else if (state == IDLE && start) begin
      a_q     <= a;
      b_q     <= b;
      carry_q <= cin;
      idx     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else if (state == RUN) begin
      sum[idx*8 +: 8] <= s_byte;
      carry_q <= c8;
      if (last) cout <= c8;
      else idx <= idx + 1'b1;
    end
  assign busy = state != IDLE;
  assign done = state == DONE;
endmodule

// File: tb/tb_byte_serial_adder.sv
// tb_byte_serial_adder: directed vectors checked against a cycle-count/arithmetic model
module tb_byte_serial_adder;
  localparam int NB = 4;
  localparam int W = 8 * NB;
  logic clk = 0, reset = 0, start = 1, cin = 0;
  logic [W-1:0] a = '0, b = '0, sum;
  logic busy, done, cout;
  int total = 0, bad = 0, cnt = 0, ndone = 0;
  logic [W:0] exp_res = '0;
  bit chk_en = 0;

  byte_serial_adder #(.NBYTES(NB)) dut (.clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .cin(cin), .busy(busy), .done(done), .sum(sum), .cout(cout));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // model: cnt 0 = idle, 1..NB = running, NB+1 = done cycle
  always @(posedge clk or negedge reset)
    if (!reset) begin
      cnt <= 0;
      exp_res <= '0;
    end else if (cnt == 0) begin
      if (start) begin
        cnt <= 1;
        exp_res <= {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      end
    end else cnt <= cnt == NB + 1 ? 0 : cnt + 1;

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("busy", 64'(busy), 64'(cnt != 0));
      chk("done", 64'(done), 64'(cnt == NB + 1));
      if (cnt == 0 || cnt == NB + 1) chk("result", 64'({cout, sum}), 64'(exp_res));
      if (done) ndone++;
    end
  end

  task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc,
                        input logic [W-1:0] es, input logic ec);
    int n;
    @(negedge clk);
    a = va; b = vb; cin = vc; start = 1;
    @(negedge clk);
    start = 0;
    a = ~va; b = ~vb; cin = ~vc;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 64'(n), 64'(NB));
    chk("sum_lit", 64'(sum), 64'(es));
    chk("cout_lit", 64'(cout), 64'(ec));
    @(negedge clk);
    chk("busy_after", 64'(busy), 64'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    chk_en = 1;
    @(negedge clk);
    start = 0;
    reset = 1;
    repeat (2) @(negedge clk);
    run_op(32'h00000017, 32'h00000013, 0, 32'h0000002A, 0);
    run_op(32'h00FFFFFF, 32'h00000001, 0, 32'h01000000, 0);
    run_op(32'hFFFFFFFF, 32'h00000000, 1, 32'h00000000, 1);
    run_op(32'h80000000, 32'h80000000, 0, 32'h00000000, 1);
    run_op(32'h12345678, 32'h9ABCDEF0, 1, 32'hACF13569, 0);
    // start while busy is ignored
    ndone = 0;
    @(negedge clk);
    a = 5; b = 7; cin = 0; start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    a = 32'hFF; b = 32'hFF; start = 1;
    @(negedge clk);
    start = 0;
    repeat (8) @(negedge clk);
    chk("busy_dones", 64'(ndone), 64'd1);
    chk("busy_sum", 64'(sum), 64'h0000000C);
    // reset mid-run
    ndone = 0;
    @(negedge clk);
    a = 32'h0000FFFF; b = 32'h00000001; start = 1;
    @(negedge clk);
    start = 0;
    repeat (2) @(negedge clk);
    reset = 0;
    #1;
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_done", 64'(done), 64'd0);
    chk("mid_sum", 64'({cout, sum}), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1;
    chk("mid_nodone", 64'(ndone), 64'd0);
    run_op(32'h00000001, 32'h00000002, 0, 32'h00000003, 0);
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
